ps2_key_buffer_ctrl: RTL
========================

Name: ps2_key_buffer_ctrl

Overview:
- Sequences the PS/2 keyboard receiver and turns raw scan-code bytes into key events.
- Folds E0 (extended) and F0 (break) prefixes into each event.
- Writes each event into a circular buffer in data memory. The buffer occupies a fixed window starting at BASE_ADDR.
- Gets the memory write port from the CPU-side arbiter through a request/grant handshake, and throttles the receiver through rx_en when the buffer is full.

Parameters:
- BASE_ADDR, 32'h0000_1000: byte address of buffer entry 0, word aligned.
- DEPTH, 16: number of buffer entries; must be a power of 2.
- PTR_W, 4: pointer width; equals log2(DEPTH).

Ports:
- clk, input, 1: system clock.
- reset, input, 1: synchronous, active-low reset (0 = reset).
- rx_done_tick, input, 1: one-cycle pulse from the receiver when a frame has been received.
- rx_data, input, 8: received byte; valid in the cycle rx_done_tick=1.
- rx_en, output, 1: receiver enable; the receiver starts a new frame only while this is 1.
- mem_gnt, input, 1: arbiter grant; the write port is ours in this cycle.
- MemWriteKey, output, 1: write request/strobe.
- Addr, output, 32: write byte address.
- dout_ram, output, 32: write data.
- rd_ptr, input, PTR_W: consumer (software) read index.
- wr_ptr, output, PTR_W: producer index, i.e. the next slot to be written.
- overflow, output, 1: sticky flag; an event was dropped.
- clr_overflow, input, 1: one-cycle pulse that clears overflow.

Behaviour:
- Reset (reset=0 at a clk edge):
  - state=IDLE; ext=0, brk=0, code=0; wr_ptr=0; overflow=0.
  - Outputs: MemWriteKey=0, Addr=BASE_ADDR, dout_ram=0, rx_en=1.
  - Reset mid-write aborts the write: no pointer advance, pending event lost.
- full = ((wr_ptr+1) mod DEPTH == rd_ptr); empty = (wr_ptr == rd_ptr). One slot is always left unused.
- rx_en = ~full, combinational from wr_ptr and rd_ptr.
- FSM states: IDLE, WRITE.
- IDLE, on rx_done_tick:
  - rx_data=8'hE0: ext<=1, stay IDLE.
  - rx_data=8'hF0: brk<=1, stay IDLE.
  - Any other byte with full=0: code<=rx_data, go to WRITE.
  - Any other byte with full=1: drop the event, overflow<=1, ext<=0, brk<=0, stay IDLE.
  - A repeated prefix simply keeps its flag set (E0 E0 = single ext).
- WRITE:
  - MemWriteKey=1 throughout.
  - Addr = BASE_ADDR + {wr_ptr, 2'b00}; upper bits zero-extended, no carry beyond 32 bits.
  - dout_ram = {1'b1, 21'b0, ext, brk, code[7:0]}. Bit 31 is the valid mark, bit 9 is ext, bit 8 is brk.
  - The write commits in the cycle where MemWriteKey=1 and mem_gnt=1.
  - On that edge: wr_ptr<=wr_ptr+1 (wraps DEPTH-1 -> 0), ext<=0, brk<=0, state<=IDLE.
  - If mem_gnt=0 the request holds with Addr and dout_ram stable; there is no timeout.
  - rx_done_tick while in WRITE: the byte is dropped and overflow<=1. The event being written is unaffected.
- Outside WRITE: MemWriteKey=0. Addr still reflects the current wr_ptr. dout_ram=0.
- Latency: the first MemWriteKey=1 occurs 1 cycle after the rx_done_tick of the final byte. If mem_gnt is already 1, the write commits on that same cycle's edge, so the total is 2 edges from the tick.
- overflow:
  - Set and clear are both synchronous.
  - If a set condition and clr_overflow occur in the same cycle, set wins.
- rd_ptr is used as-is; no synchronisation is required because it is in the same clock domain.
- A rd_ptr change that makes the buffer full during WRITE does not cancel the pending write. Fullness was already checked on entry to WRITE.

Test Plan:
- Plain make code: after reset, tick rx_data=8'h1C, mem_gnt=1 -> one cycle later MemWriteKey=1, Addr=32'h1000, dout_ram=32'h8000_001C; next edge wr_ptr=1, MemWriteKey=0.
- Extended break sequence: ticks E0, F0, 75 -> dout_ram=32'h8000_0375 at Addr=BASE_ADDR+4*wr_ptr; flags read 0 afterwards; a following tick of 8'h75 writes 32'h8000_0075.
- Grant stall: hold mem_gnt=0 for 5 cycles after the 8'h2B event -> MemWriteKey, Addr and dout_ram held stable, wr_ptr unchanged; raise mem_gnt -> commit on that edge.
- Full/wrap:
  - rd_ptr=0, write 15 events -> wr_ptr=15, rx_en=0.
  - 16th code tick -> no write, overflow=1.
  - Set rd_ptr=1 -> rx_en=1; next event writes Addr=32'h103C and wr_ptr wraps to 0.
- Overflow priority: clr_overflow pulsed in the same cycle as a dropped event -> overflow stays 1; a clr_overflow pulse alone -> overflow=0.
- Reset mid-operation: drive reset=0 during WRITE with mem_gnt=0 -> next edge MemWriteKey=0, wr_ptr=0, flags=0, rx_en=1; an async-looking reset pulse between edges has no effect.

Source files
------------

// File: rtl/ps2_key_buffer_ctrl.sv
// PS/2 key event buffer controller.
//
// Turns raw scan-code bytes from a PS/2 receiver into key events. The E0 (extended)
// and F0 (break) prefixes are folded into the event that follows them. Each event is
// written as one 32-bit word into a circular buffer in data memory, starting at
// BASE_ADDR. The memory write port is shared with the CPU: a write is requested
// with MemWriteKey and commits in the cycle the arbiter also drives mem_gnt.
//
// Event word layout:
//   [31]    valid mark (always 1)
//   [30:10] zero
//   [9]     extended (E0 seen)
//   [8]     break (F0 seen)
//   [7:0]   scan code
//
// Ports:
//   clk          in   system clock
//   reset        in   synchronous reset, active low (0 = reset)
//   rx_done_tick in   one-cycle pulse, a byte has been received
//   rx_data      in   received byte, valid with rx_done_tick
//   rx_en        out  receiver enable, low while the buffer is full
//   mem_gnt      in   arbiter grant for the memory write port
//   MemWriteKey  out  write request / strobe
//   Addr         out  write byte address
//   dout_ram     out  write data (event word during a write, else 0)
//   rd_ptr       in   consumer read index
//   wr_ptr       out  producer index, next slot to be written
//   overflow     out  sticky, an event or byte was dropped
//   clr_overflow in   one-cycle pulse clearing overflow
module ps2_key_buffer_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned PTR_W     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx_done_tick,
  input  logic [7:0]       rx_data,
  output logic             rx_en,
  input  logic             mem_gnt,
  output logic             MemWriteKey,
  output logic [31:0]      Addr,
  output logic [31:0]      dout_ram,
  input  logic [PTR_W-1:0] rd_ptr,
  output logic [PTR_W-1:0] wr_ptr,
  output logic             overflow,
  input  logic             clr_overflow
);

  localparam logic [7:0]       PrefixExt = 8'hE0;
  localparam logic [7:0]       PrefixBrk = 8'hF0;
  localparam logic [PTR_W-1:0] PtrMax    = PTR_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    StIdle,
    StWrite
  } state_e;

  state_e           state_q, state_d;
  logic             ext_q, ext_d;
  logic             brk_q, brk_d;
  logic [7:0]       code_q, code_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic             overflow_q, overflow_d;

  logic [PTR_W-1:0] wr_ptr_inc;
  logic             full;
  logic             ovf_set;

  // Explicit wrap keeps the pointer correct even if PTR_W were wider than needed.
  assign wr_ptr_inc = (wr_ptr_q == PtrMax) ? '0 : wr_ptr_q + 1'b1;

  // One slot stays unused so that full and empty are distinguishable.
  assign full  = (wr_ptr_inc == rd_ptr);
  assign rx_en = ~full;

  // Address tracks wr_ptr in every state; only the strobe and data are gated.
  assign Addr   = BASE_ADDR + {{(30 - PTR_W){1'b0}}, wr_ptr_q, 2'b00};
  assign wr_ptr = wr_ptr_q;
  assign overflow = overflow_q;

  always_comb begin
    state_d     = state_q;
    ext_d       = ext_q;
    brk_d       = brk_q;
    code_d      = code_q;
    wr_ptr_d    = wr_ptr_q;
    ovf_set     = 1'b0;
    MemWriteKey = 1'b0;
    dout_ram    = 32'h0;

    unique case (state_q)
      StIdle: begin
        if (rx_done_tick) begin
          if (rx_data == PrefixExt) begin
            ext_d = 1'b1;
          end else if (rx_data == PrefixBrk) begin
            brk_d = 1'b1;
          end else if (!full) begin
            code_d  = rx_data;
            state_d = StWrite;
          end else begin
            // No room: the whole event, prefixes included, is discarded.
            ovf_set = 1'b1;
            ext_d   = 1'b0;
            brk_d   = 1'b0;
          end
        end
      end

      StWrite: begin
        MemWriteKey = 1'b1;
        dout_ram    = {1'b1, 21'b0, ext_q, brk_q, code_q};
        // Bytes arriving while a write is pending cannot be queued.
        if (rx_done_tick) begin
          ovf_set = 1'b1;
        end
        // Fullness was checked on entry; a later rd_ptr change never cancels the write.
        if (mem_gnt) begin
          wr_ptr_d = wr_ptr_inc;
          ext_d    = 1'b0;
          brk_d    = 1'b0;
          state_d  = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // Set has priority over a simultaneous clear.
    if (ovf_set) begin
      overflow_d = 1'b1;
    end else if (clr_overflow) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      code_q     <= 8'h00;
      wr_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ext_q      <= ext_d;
      brk_q      <= brk_d;
      code_q     <= code_d;
      wr_ptr_q   <= wr_ptr_d;
      overflow_q <= overflow_d;
    end
  end

endmodule
